tx_trn_arbiter: RTL



---
 rtl/tx_trn_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/tx_trn_arbiter.sv
// Round-robin arbiter that shares the PCIe TRN transmit local-link among NUM_REQ requesters.
// The link is offered via my_turn and held while the owner drives it; the owner's TX signals are muxed to the core.
module tx_trn_arbiter #(
  parameter int NUM_REQ      = 3,
  parameter int IDX_W        = 2,
  parameter int OFFER_CYCLES = 4
) (
  input  logic                  trn_clk,
  input  logic                  reset_n,
  output logic [NUM_REQ-1:0]    my_turn,
  input  logic [NUM_REQ-1:0]    driving_interface,
  input  logic [64*NUM_REQ-1:0] req_trn_td,
  input  logic [8*NUM_REQ-1:0]  req_trn_trem_n,
  input  logic [NUM_REQ-1:0]    req_trn_tsof_n,
  input  logic [NUM_REQ-1:0]    req_trn_teof_n,
  input  logic [NUM_REQ-1:0]    req_trn_tsrc_rdy_n,
  output logic [63:0]           trn_td,
  output logic [7:0]            trn_trem_n,
  output logic                  trn_tsof_n,
  output logic                  trn_teof_n,
  output logic                  trn_tsrc_rdy_n,
  output logic [IDX_W-1:0]      owner,
  output logic                  owner_valid,
  output logic                  err_protocol
);

  localparam int TMR_W = (OFFER_CYCLES > 1) ? $clog2(OFFER_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_OFFER = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   g_q, g_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [NUM_REQ-1:0] my_turn_q, my_turn_d;
  logic               offered_q, offered_d;
  logic               err_q, err_d;

  logic [IDX_W-1:0]   next_g_s;
  logic [NUM_REQ-1:0] g_mask_s;
  logic               drv_g_s;
  logic               others_s;
  logic               owner_valid_s;

  function automatic logic [NUM_REQ-1:0] one_hot(input logic [IDX_W-1:0] idx);
    one_hot = NUM_REQ'(1'b1) << idx;
  endfunction

  always_comb begin
    if (ptr_q == IDX_W'(NUM_REQ - 1)) begin
      next_g_s = {IDX_W{1'b0}};
    end else begin
      next_g_s = ptr_q + IDX_W'(1'b1);
    end
  end

  assign g_mask_s = one_hot(g_q);
  assign drv_g_s  = |(driving_interface & g_mask_s);
  assign others_s = |(driving_interface & ~g_mask_s);

  always_comb begin
    state_d   = state_q;
    g_d       = g_q;
    ptr_d     = ptr_q;
    timer_d   = timer_q;
    my_turn_d = my_turn_q;
    offered_d = offered_q;
    case (state_q)
      ST_ARB: begin
        if (drv_g_s) begin
          my_turn_d = {NUM_REQ{1'b0}};
          state_d   = ST_HOLD;
        end else begin
          g_d       = next_g_s;
          my_turn_d = one_hot(next_g_s);
          timer_d   = TMR_W'(OFFER_CYCLES - 1);
          offered_d = 1'b1;
          state_d   = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (drv_g_s) begin
          my_turn_d = {NUM_REQ{1'b0}};
          state_d   = ST_HOLD;
        end else if (timer_q == {TMR_W{1'b0}}) begin
          my_turn_d = {NUM_REQ{1'b0}};
          ptr_d     = g_q;
          state_d   = ST_ARB;
        end else begin
          timer_d   = timer_q - TMR_W'(1'b1);
        end
      end
      ST_HOLD: begin
        my_turn_d = {NUM_REQ{1'b0}};
        if (!drv_g_s) begin
          // the released owner goes to the back of the rotation and must be re-offered before re-claiming
          ptr_d     = g_q;
          offered_d = 1'b0;
          state_d   = ST_ARB;
        end else begin
          state_d   = ST_HOLD;
        end
      end
      default: begin
        my_turn_d = {NUM_REQ{1'b0}};
        state_d   = ST_ARB;
      end
    endcase
    if (others_s || ((state_q == ST_ARB) && drv_g_s && !offered_q)) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge trn_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_ARB;
      g_q       <= {IDX_W{1'b0}};
      ptr_q     <= IDX_W'(NUM_REQ - 1);
      timer_q   <= {TMR_W{1'b0}};
      my_turn_q <= {NUM_REQ{1'b0}};
      offered_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      g_q       <= g_d;
      ptr_q     <= ptr_d;
      timer_q   <= timer_d;
      my_turn_q <= my_turn_d;
      offered_q <= offered_d;
      err_q     <= err_d;
    end
  end

  // Zero-latency data path: only requester g is ever passed to the core.
  always_comb begin
    owner_valid_s = drv_g_s | (state_q == ST_HOLD);
    if (owner_valid_s) begin
      trn_td         = req_trn_td[64*g_q +: 64];
      trn_trem_n     = req_trn_trem_n[8*g_q +: 8];
      trn_tsof_n     = req_trn_tsof_n[g_q];
      trn_teof_n     = req_trn_teof_n[g_q];
      trn_tsrc_rdy_n = req_trn_tsrc_rdy_n[g_q];
    end else begin
      trn_td         = 64'd0;
      trn_trem_n     = 8'hFF;
      trn_tsof_n     = 1'b1;
      trn_teof_n     = 1'b1;
      trn_tsrc_rdy_n = 1'b1;
    end
  end

  assign my_turn      = my_turn_q;
  assign owner        = g_q;
  assign owner_valid  = owner_valid_s;
  assign err_protocol = err_q;

endmodule
